iic_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one I2C master (uii2c-style en/busy handshake) between NREQ requesters.
- Typical requesters: OV5640 init configurator, runtime exposure/AWB register writer, sensor ID/status reader.
- Latches the winning request, drives the master's en/busy handshake, returns read data with a per-requester done pulse.
- Watchdogs catch a hung master or bus.

---
 rtl/iic_share_arb.sv | 206 ++++++++++++++++++++
 tb/tb_iic_share_arb.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_share_arb.sv
// ============================================================================
// Module   : iic_share_arb
// Purpose  : Round-robin arbiter/sequencer sharing one en/busy-handshake I2C
//            master between NREQ requesters. Latches the winning request's
//            master fields, runs the handshake, returns read data with a
//            per-requester done pulse, and times out a hung master or bus.
// Ports    : clk_i, rst_n (sync, active-low)
//            req_i/wr_data_i/wr_cnt_i/rd_cnt_i/mode_i : per-requester request
//            gnt_o/done_o/err_o/rd_data_o             : per-requester status
//            m_*_o / m_busy_i / m_rd_data_i           : I2C master interface
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iic_share_arb #(
   parameter int          NREQ     = 2,
   parameter logic [15:0] START_TO = 16'd1000,
   parameter logic [23:0] RUN_TO   = 24'd2000000
) (
   input  logic                 clk_i,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_i,
   input  logic [NREQ*32-1:0]   wr_data_i,
   input  logic [NREQ*8-1:0]    wr_cnt_i,
   input  logic [NREQ*8-1:0]    rd_cnt_i,
   input  logic [NREQ-1:0]      mode_i,
   output logic [NREQ-1:0]      gnt_o,
   output logic [NREQ-1:0]      done_o,
   output logic                 err_o,
   output logic [31:0]          rd_data_o,
   output logic [31:0]          m_wr_data_o,
   output logic [7:0]           m_wr_cnt_o,
   output logic [7:0]           m_rd_cnt_o,
   output logic                 m_mode_o,
   output logic                 m_en_o,
   input  logic                 m_busy_i,
   input  logic [31:0]          m_rd_data_i
);

   localparam int          IDXW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [23:0] START_LAST = {8'd0, START_TO} - 24'd1;
   localparam logic [23:0] RUN_LAST   = RUN_TO - 24'd1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_RUN    = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [23:0]       timer_q, timer_d;
   logic [IDXW-1:0]   last_q, last_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              err_flag_q, err_flag_d;
   logic [31:0]       rd_data_q, rd_data_d;
   logic [31:0]       m_wr_data_q, m_wr_data_d;
   logic [7:0]        m_wr_cnt_q, m_wr_cnt_d;
   logic [7:0]        m_rd_cnt_q, m_rd_cnt_d;
   logic              m_mode_q, m_mode_d;
   logic              m_en_q, m_en_d;

   // Per-requester views of the packed request buses
   logic [31:0] req_wr_data [NREQ];
   logic [7:0]  req_wr_cnt  [NREQ];
   logic [7:0]  req_rd_cnt  [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_slice
      assign req_wr_data[g] = wr_data_i[g*32 +: 32];
      assign req_wr_cnt[g]  = wr_cnt_i[g*8 +: 8];
      assign req_rd_cnt[g]  = rd_cnt_i[g*8 +: 8];
   end

   // Round-robin search: first set request strictly after the last winner,
   // wrapping, so the last winner is considered last.
   logic            win_found;
   logic [IDXW-1:0] win_idx;
   logic [IDXW-1:0] cand;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = last_q;
      for (int k = 0; k < NREQ; k++) begin
         if (cand == IDXW'(NREQ-1)) cand = '0;
         else                       cand = cand + 1'b1;
         if (!win_found && req_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         last_q      <= IDXW'(NREQ-1);
         idx_q       <= '0;
         gnt_q       <= '0;
         err_flag_q  <= 1'b0;
         rd_data_q   <= '0;
         m_wr_data_q <= '0;
         m_wr_cnt_q  <= '0;
         m_rd_cnt_q  <= '0;
         m_mode_q    <= 1'b0;
         m_en_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         last_q      <= last_d;
         idx_q       <= idx_d;
         gnt_q       <= gnt_d;
         err_flag_q  <= err_flag_d;
         rd_data_q   <= rd_data_d;
         m_wr_data_q <= m_wr_data_d;
         m_wr_cnt_q  <= m_wr_cnt_d;
         m_rd_cnt_q  <= m_rd_cnt_d;
         m_mode_q    <= m_mode_d;
         m_en_q      <= m_en_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      last_d      = last_q;
      idx_d       = idx_q;
      gnt_d       = gnt_q;
      err_flag_d  = err_flag_q;
      rd_data_d   = rd_data_q;
      m_wr_data_d = m_wr_data_q;
      m_wr_cnt_d  = m_wr_cnt_q;
      m_rd_cnt_d  = m_rd_cnt_q;
      m_mode_d    = m_mode_q;
      m_en_d      = m_en_q;

      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               gnt_d          = '0;
               gnt_d[win_idx] = 1'b1;
               idx_d          = win_idx;
               // Master fields are frozen here for the whole transaction
               m_wr_data_d    = req_wr_data[win_idx];
               m_wr_cnt_d     = req_wr_cnt[win_idx];
               m_rd_cnt_d     = req_rd_cnt[win_idx];
               m_mode_d       = mode_i[win_idx];
               m_en_d         = 1'b1;
               timer_d        = '0;
               state_d        = S_LAUNCH;
            end
         end

         S_LAUNCH: begin
            if (m_busy_i) begin
               m_en_d  = 1'b0;
               timer_d = '0;
               state_d = S_RUN;
            end else if (timer_q == START_LAST) begin
               m_en_d     = 1'b0;
               err_flag_d = 1'b1;
               state_d    = S_DONE;
            end else if (timer_q != '1) begin
               timer_d = timer_q + 24'd1;
            end
         end

         S_RUN: begin
            if (!m_busy_i) begin
               rd_data_d = m_rd_data_i;
               state_d   = S_DONE;
            end else if (timer_q == RUN_LAST) begin
               err_flag_d = 1'b1;
               state_d    = S_DONE;
            end else if (timer_q != '1) begin
               timer_d = timer_q + 24'd1;
            end
         end

         S_DONE: begin
            last_d     = idx_q;
            err_flag_d = 1'b0;
            gnt_d      = '0;
            state_d    = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Done/err are decoded from the DONE state so they last exactly one cycle
   assign done_o      = (state_q == S_DONE) ? gnt_q : '0;
   assign err_o       = (state_q == S_DONE) && err_flag_q;
   assign gnt_o       = gnt_q;
   assign rd_data_o   = rd_data_q;
   assign m_wr_data_o = m_wr_data_q;
   assign m_wr_cnt_o  = m_wr_cnt_q;
   assign m_rd_cnt_o  = m_rd_cnt_q;
   assign m_mode_o    = m_mode_q;
   assign m_en_o      = m_en_q;

endmodule

`default_nettype wire

// File: tb/tb_iic_share_arb.sv
// ============================================================================
// Module   : tb_iic_share_arb
// Purpose  : Directed self-checking bench for iic_share_arb (NREQ=2,
//            START_TO=16, RUN_TO=60) with a hand-driven master model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iic_share_arb;

   localparam int NREQ = 2;

   logic               clk_i = 1'b0;
   logic               rst_n;
   logic [NREQ-1:0]    req_i;
   logic [NREQ*32-1:0] wr_data_i;
   logic [NREQ*8-1:0]  wr_cnt_i;
   logic [NREQ*8-1:0]  rd_cnt_i;
   logic [NREQ-1:0]    mode_i;
   logic [NREQ-1:0]    gnt_o;
   logic [NREQ-1:0]    done_o;
   logic               err_o;
   logic [31:0]        rd_data_o;
   logic [31:0]        m_wr_data_o;
   logic [7:0]         m_wr_cnt_o;
   logic [7:0]         m_rd_cnt_o;
   logic               m_mode_o;
   logic               m_en_o;
   logic               m_busy_i;
   logic [31:0]        m_rd_data_i;

   int errors    = 0;
   int checks    = 0;
   int multi_gnt = 0;

   iic_share_arb #(
      .NREQ     (NREQ),
      .START_TO (16'd16),
      .RUN_TO   (24'd60)
   ) dut (
      .clk_i       (clk_i),
      .rst_n       (rst_n),
      .req_i       (req_i),
      .wr_data_i   (wr_data_i),
      .wr_cnt_i    (wr_cnt_i),
      .rd_cnt_i    (rd_cnt_i),
      .mode_i      (mode_i),
      .gnt_o       (gnt_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .rd_data_o   (rd_data_o),
      .m_wr_data_o (m_wr_data_o),
      .m_wr_cnt_o  (m_wr_cnt_o),
      .m_rd_cnt_o  (m_rd_cnt_o),
      .m_mode_o    (m_mode_o),
      .m_en_o      (m_en_o),
      .m_busy_i    (m_busy_i),
      .m_rd_data_i (m_rd_data_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Advance one cycle and sample 1 time unit after the edge
   task automatic tick;
      @(posedge clk_i);
      #1;
      if (!$onehot0(gnt_o)) multi_gnt++;
   endtask

   task automatic wait_gnt(output int cyc);
      cyc = 0;
      while (gnt_o == '0 && cyc < 50) begin
         tick;
         cyc++;
      end
   endtask

   // Master model: busy rises dly cycles from now, stays high len cycles
   task automatic serve(input int dly, input int len, input logic [31:0] rd);
      repeat (dly) tick;
      m_busy_i = 1'b1;
      repeat (len) tick;
      m_busy_i    = 1'b0;
      m_rd_data_i = rd;
   endtask

   task automatic wait_done(output logic [NREQ-1:0] d, output int cyc);
      cyc = 1;
      tick;
      while (done_o == '0 && cyc < 300) begin
         tick;
         cyc++;
      end
      d = done_o;
   endtask

   task automatic test_reset;
      req_i = '0; wr_data_i = '0; wr_cnt_i = '0; rd_cnt_i = '0; mode_i = '0;
      m_busy_i = 1'b0; m_rd_data_i = '0;
      rst_n = 1'b0;
      repeat (3) tick;
      checks++;
      if ({gnt_o, done_o, err_o, m_en_o, m_mode_o, m_wr_cnt_o, m_rd_cnt_o,
           m_wr_data_o, rd_data_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: gnt=%b done=%b err=%b en=%b wd=%h rd=%h, all required 0",
                  gnt_o, done_o, err_o, m_en_o, m_wr_data_o, rd_data_o);
      end
      rst_n = 1'b1;
      tick;
      checks++;
      if (gnt_o !== 2'b00 || m_en_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: gnt=%b en=%b, required 00/0", gnt_o, m_en_o);
      end
   endtask

   task automatic test_single;
      int dcnt;
      wr_data_i[31:0] = 32'h1100_3878;
      wr_cnt_i[7:0]   = 8'd3;
      mode_i          = 2'b00;
      req_i           = 2'b01;
      tick;
      checks++;
      if (gnt_o !== 2'b01 || m_en_o !== 1'b1) begin
         errors++;
         $display("FAIL single_grant: gnt=%b en=%b, required 01/1", gnt_o, m_en_o);
      end
      checks++;
      if (m_wr_data_o !== 32'h1100_3878 || m_wr_cnt_o !== 8'd3) begin
         errors++;
         $display("FAIL single_fields: wd=%h wc=%0d, required 11003878/3", m_wr_data_o, m_wr_cnt_o);
      end
      req_i = 2'b00;
      tick; tick;
      m_busy_i = 1'b1;
      checks++;
      if (m_en_o !== 1'b1) begin
         errors++;
         $display("FAIL single_en_hold: en=%b, required 1", m_en_o);
      end
      tick;
      checks++;
      if (m_en_o !== 1'b0) begin
         errors++;
         $display("FAIL single_en_fall: en=%b, required 0", m_en_o);
      end
      dcnt = 0;
      repeat (49) begin
         tick;
         if (done_o != '0) dcnt++;
      end
      m_busy_i = 1'b0;
      tick;
      if (done_o != '0) dcnt++;
      checks++;
      if (done_o !== 2'b01 || err_o !== 1'b0 || gnt_o !== 2'b01) begin
         errors++;
         $display("FAIL single_done: done=%b err=%b gnt=%b, required 01/0/01", done_o, err_o, gnt_o);
      end
      repeat (8) begin
         tick;
         if (done_o != '0) dcnt++;
      end
      checks++;
      if (dcnt != 1) begin
         errors++;
         $display("FAIL single_done_count: got %0d pulses, required 1", dcnt);
      end
   endtask

   task automatic test_contention;
      logic [NREQ-1:0] order [4];
      logic [NREQ-1:0] exp_order [4];
      logic [NREQ-1:0] d;
      int c;
      exp_order[0] = 2'b01; exp_order[1] = 2'b10;
      exp_order[2] = 2'b01; exp_order[3] = 2'b10;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      multi_gnt = 0;
      req_i = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_gnt(c);
         order[i] = gnt_o;
         serve(1, 3, 32'h0);
         wait_done(d, c);
         tick;
      end
      req_i = 2'b00;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (order[i] !== exp_order[i]) begin
            errors++;
            $display("FAIL rr_order[%0d]: gnt=%b, required %b", i, order[i], exp_order[i]);
         end
      end
      checks++;
      if (multi_gnt != 0) begin
         errors++;
         $display("FAIL rr_onehot: %0d cycles with multiple grants, required 0", multi_gnt);
      end
   endtask

   task automatic test_read_return;
      logic [NREQ-1:0] d;
      int c;
      mode_i        = 2'b01;
      rd_cnt_i[7:0] = 8'd1;
      req_i         = 2'b01;
      wait_gnt(c);
      checks++;
      if (m_mode_o !== 1'b1 || m_rd_cnt_o !== 8'd1) begin
         errors++;
         $display("FAIL read_fields: mode=%b rc=%0d, required 1/1", m_mode_o, m_rd_cnt_o);
      end
      req_i = 2'b00;
      serve(2, 5, 32'h0000_0056);
      wait_done(d, c);
      checks++;
      if (d !== 2'b01 || rd_data_o !== 32'h0000_0056) begin
         errors++;
         $display("FAIL read_data: done=%b rd=%h, required 01/00000056", d, rd_data_o);
      end
      tick;
      mode_i = 2'b00;
   endtask

   task automatic test_start_timeout;
      logic [NREQ-1:0] d;
      int c;
      int en_cnt;
      wr_data_i[63:32] = 32'h2200_3C78;
      req_i = 2'b10;
      wait_gnt(c);
      req_i = 2'b00;
      en_cnt = 0;
      while (m_en_o && en_cnt < 100) begin
         en_cnt++;
         tick;
      end
      checks++;
      if (en_cnt != 16) begin
         errors++;
         $display("FAIL start_to_len: en high %0d cycles, required 16", en_cnt);
      end
      checks++;
      if (done_o !== 2'b10 || err_o !== 1'b1) begin
         errors++;
         $display("FAIL start_to_done: done=%b err=%b, required 10/1", done_o, err_o);
      end
      tick;
      req_i = 2'b01;
      wait_gnt(c);
      checks++;
      if (gnt_o !== 2'b01) begin
         errors++;
         $display("FAIL start_to_next_gnt: gnt=%b, required 01", gnt_o);
      end
      req_i = 2'b00;
      serve(1, 4, 32'h0000_0077);
      wait_done(d, c);
      checks++;
      if (d !== 2'b01 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL start_to_next_done: done=%b err=%b, required 01/0", d, err_o);
      end
      tick;
   endtask

   task automatic test_latching;
      logic [NREQ-1:0] d;
      int c;
      wr_data_i[31:0] = 32'hAAAA_BBBB;
      req_i = 2'b01;
      wait_gnt(c);
      tick;
      wr_data_i[31:0] = 32'hDEAD_BEEF;
      req_i = 2'b00;
      tick;
      checks++;
      if (m_wr_data_o !== 32'hAAAA_BBBB) begin
         errors++;
         $display("FAIL latch_data: wd=%h, required aaaabbbb", m_wr_data_o);
      end
      serve(1, 4, 32'h0000_1234);
      wait_done(d, c);
      checks++;
      if (d !== 2'b01 || m_wr_data_o !== 32'hAAAA_BBBB || rd_data_o !== 32'h0000_1234) begin
         errors++;
         $display("FAIL latch_done: done=%b wd=%h rd=%h, required 01/aaaabbbb/00001234",
                  d, m_wr_data_o, rd_data_o);
      end
      tick;
   endtask

   task automatic test_run_timeout;
      int c;
      req_i = 2'b10;
      wait_gnt(c);
      req_i = 2'b00;
      tick;
      m_busy_i    = 1'b1;
      m_rd_data_i = 32'hFFFF_FFFF;
      tick;
      checks++;
      if (m_en_o !== 1'b0) begin
         errors++;
         $display("FAIL run_to_en: en=%b, required 0", m_en_o);
      end
      c = 0;
      while (done_o == '0 && c < 200) begin
         tick;
         c++;
      end
      checks++;
      if (c != 60) begin
         errors++;
         $display("FAIL run_to_len: done after %0d RUN cycles, required 60", c);
      end
      checks++;
      if (done_o !== 2'b10 || err_o !== 1'b1 || rd_data_o !== 32'h0000_1234) begin
         errors++;
         $display("FAIL run_to_done: done=%b err=%b rd=%h, required 10/1/00001234",
                  done_o, err_o, rd_data_o);
      end
      m_busy_i = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid_run;
      logic [NREQ-1:0] d;
      int c;
      int dcnt;
      req_i = 2'b01;
      wait_gnt(c);
      req_i = 2'b00;
      tick;
      m_busy_i = 1'b1;
      tick; tick;
      rst_n = 1'b0;
      tick;
      checks++;
      if ({gnt_o, done_o, err_o, m_en_o, m_mode_o, m_wr_cnt_o, m_rd_cnt_o,
           m_wr_data_o, rd_data_o} !== '0) begin
         errors++;
         $display("FAIL midrun_reset: gnt=%b done=%b err=%b en=%b wd=%h rd=%h, all required 0",
                  gnt_o, done_o, err_o, m_en_o, m_wr_data_o, rd_data_o);
      end
      rst_n    = 1'b1;
      m_busy_i = 1'b0;
      dcnt = 0;
      repeat (5) begin
         tick;
         if (done_o != '0) dcnt++;
      end
      checks++;
      if (dcnt != 0) begin
         errors++;
         $display("FAIL midrun_no_done: %0d done pulses, required 0", dcnt);
      end
      req_i = 2'b11;
      wait_gnt(c);
      checks++;
      if (gnt_o !== 2'b01) begin
         errors++;
         $display("FAIL midrun_first_gnt: gnt=%b, required 01", gnt_o);
      end
      req_i = 2'b00;
      serve(1, 2, 32'h0);
      wait_done(d, c);
      tick;
   endtask

   initial begin
      test_reset;
      test_single;
      test_contention;
      test_read_return;
      test_start_timeout;
      test_latching;
      test_run_timeout;
      test_reset_mid_run;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
